// File: rtl/bram_acc_engine.sv
// Multi-lane accumulate engine: streams rows from BRAM0, sums each lane in its own
// accumulator and writes running or final sums to BRAM1.
module bram_acc_engine #(
   parameter int LANES    = 4,
   parameter int IN_W     = 8,
   parameter int ACC_W    = 16,
   parameter int AWIDTH   = 8,
   parameter int SATURATE = 0
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start_i,
   input  logic [AWIDTH:0]          run_count_i,
   input  logic                     mode_i,
   input  logic [LANES*IN_W-1:0]    q_b0_i,
   input  logic [LANES*ACC_W-1:0]   q_b1_i,
   output logic                     idle_o,
   output logic                     read_o,
   output logic                     write_o,
   output logic                     done_o,
   output logic [AWIDTH-1:0]        addr_b0_o,
   output logic                     ce_b0_o,
   output logic                     we_b0_o,
   output logic [LANES*IN_W-1:0]    d_b0_o,
   output logic [AWIDTH-1:0]        addr_b1_o,
   output logic                     ce_b1_o,
   output logic                     we_b1_o,
   output logic [LANES*ACC_W-1:0]   d_b1_o
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                   state_reg, state_next;
   logic [AWIDTH:0]          count_reg;
   logic                     mode_reg;
   logic [AWIDTH-1:0]        rd_addr_reg;
   logic [AWIDTH-1:0]        wr_addr_reg;
   logic                     data_valid_reg;
   logic                     wr_valid_reg;
   logic [LANES*ACC_W-1:0]   acc_bus;
   logic [AWIDTH:0]          last_addr;
   logic                     start_ok;
   logic                     rd_last;
   logic                     wr_last;
   logic                     wr_fire;
   logic                     unused_q_b1;

   assign unused_q_b1 = ^q_b1_i;

   assign last_addr = count_reg - (AWIDTH+1)'(1);
   assign start_ok  = (state_reg == S_IDLE) && start_i;
   assign rd_last   = ({1'b0, rd_addr_reg} == last_addr);
   assign wr_last   = ({1'b0, wr_addr_reg} == last_addr);
   // Final-only mode fires on the slot of the last running-sum write.
   assign wr_fire   = wr_valid_reg && (!mode_reg || wr_last);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (start_i) state_next = (run_count_i == '0) ? S_DONE : S_RUN;
         S_RUN:   if (rd_last) state_next = S_DRAIN;
         S_DRAIN: if (wr_valid_reg && wr_last) state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= S_IDLE;
         count_reg      <= '0;
         mode_reg       <= 1'b0;
         rd_addr_reg    <= '0;
         wr_addr_reg    <= '0;
         data_valid_reg <= 1'b0;
         wr_valid_reg   <= 1'b0;
      end else begin
         state_reg      <= state_next;
         data_valid_reg <= (state_reg == S_RUN);
         wr_valid_reg   <= data_valid_reg;
         if (start_ok) begin
            count_reg   <= run_count_i;
            mode_reg    <= mode_i;
            rd_addr_reg <= '0;
            wr_addr_reg <= '0;
         end else begin
            // Counters hold at N-1 so a full-depth job never wraps.
            if ((state_reg == S_RUN) && !rd_last)
               rd_addr_reg <= rd_addr_reg + 1'b1;
            if (wr_valid_reg && !wr_last)
               wr_addr_reg <= wr_addr_reg + 1'b1;
         end
      end
   end

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [ACC_W-1:0] acc_lane_reg;
      logic [ACC_W:0]   sum;
      logic [ACC_W-1:0] acc_next;

      assign sum = {1'b0, acc_lane_reg} + (ACC_W+1)'(q_b0_i[gi*IN_W +: IN_W]);

      if (SATURATE != 0) begin : g_sat
         assign acc_next = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
      end else begin : g_wrap
         logic unused_carry;
         assign unused_carry = sum[ACC_W];
         assign acc_next     = sum[ACC_W-1:0];
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n)
            acc_lane_reg <= '0;
         else if (start_ok)
            acc_lane_reg <= '0;
         else if (data_valid_reg)
            acc_lane_reg <= acc_next;
      end

      assign acc_bus[gi*ACC_W +: ACC_W] = acc_lane_reg;
   end

   assign idle_o    = (state_reg == S_IDLE);
   assign done_o    = (state_reg == S_DONE);
   assign ce_b0_o   = (state_reg == S_RUN);
   assign read_o    = ce_b0_o;
   assign addr_b0_o = ce_b0_o ? rd_addr_reg : '0;
   assign we_b0_o   = 1'b0;
   assign d_b0_o    = '0;
   assign write_o   = wr_fire;
   assign ce_b1_o   = wr_fire;
   assign we_b1_o   = wr_fire;
   assign addr_b1_o = (wr_fire && !mode_reg) ? wr_addr_reg : '0;
   assign d_b1_o    = wr_fire ? acc_bus : '0;

endmodule

// File: tb/tb_bram_acc_engine.sv
// Bench for bram_acc_engine: BRAM models, prefix-sum reference model and a
// per-cycle compare process, plus directed literal checks and randomized jobs.
module tb_bram_acc_engine;
   localparam int LANES = 4;
   localparam int IN_W  = 8;
   localparam int ACC_W = 16;
   localparam int AW    = 8;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              start_i = 1'b0;
   logic              mode_i = 1'b0;
   logic [AW:0]       run_count_i = '0;
   logic [31:0]       q_b0 = '0;
   logic [63:0]       q_b1 = '0;
   logic              idle_o, read_o, write_o, done_o, ce_b0, we_b0, ce_b1, we_b1;
   logic [AW-1:0]     addr_b0, addr_b1;
   logic [31:0]       d_b0;
   logic [63:0]       d_b1;

   always #5 clk = ~clk;

   bram_acc_engine #(.LANES(LANES), .IN_W(IN_W), .ACC_W(ACC_W), .AWIDTH(AW), .SATURATE(0)) dut (
      .clk(clk), .reset_n(reset_n), .start_i(start_i), .run_count_i(run_count_i), .mode_i(mode_i),
      .q_b0_i(q_b0), .q_b1_i(q_b1), .idle_o(idle_o), .read_o(read_o), .write_o(write_o),
      .done_o(done_o), .addr_b0_o(addr_b0), .ce_b0_o(ce_b0), .we_b0_o(we_b0), .d_b0_o(d_b0),
      .addr_b1_o(addr_b1), .ce_b1_o(ce_b1), .we_b1_o(we_b1), .d_b1_o(d_b1));

   // Two narrow instances for clamp versus wrap behaviour, fed all-0xFF rows.
   logic              start_s = 1'b0;
   logic [AW:0]       run_s = 9'd3;
   logic [31:0]       q_s = 32'hFFFF_FFFF;
   logic [31:0]       q1_s = '0;
   logic              idle_sa, rd_sa, wr_sa, dn_sa, ce0_sa, we0_sa, ce1_sa, we1_sa;
   logic              idle_wa, rd_wa, wr_wa, dn_wa, ce0_wa, we0_wa, ce1_wa, we1_wa;
   logic [AW-1:0]     a0_sa, a1_sa, a0_wa, a1_wa;
   logic [31:0]       d0_sa, d1_sa, d0_wa, d1_wa;

   bram_acc_engine #(.LANES(4), .IN_W(8), .ACC_W(8), .AWIDTH(AW), .SATURATE(1)) dut_sat (
      .clk(clk), .reset_n(reset_n), .start_i(start_s), .run_count_i(run_s), .mode_i(1'b0),
      .q_b0_i(q_s), .q_b1_i(q1_s), .idle_o(idle_sa), .read_o(rd_sa), .write_o(wr_sa),
      .done_o(dn_sa), .addr_b0_o(a0_sa), .ce_b0_o(ce0_sa), .we_b0_o(we0_sa), .d_b0_o(d0_sa),
      .addr_b1_o(a1_sa), .ce_b1_o(ce1_sa), .we_b1_o(we1_sa), .d_b1_o(d1_sa));

   bram_acc_engine #(.LANES(4), .IN_W(8), .ACC_W(8), .AWIDTH(AW), .SATURATE(0)) dut_wrap (
      .clk(clk), .reset_n(reset_n), .start_i(start_s), .run_count_i(run_s), .mode_i(1'b0),
      .q_b0_i(q_s), .q_b1_i(q1_s), .idle_o(idle_wa), .read_o(rd_wa), .write_o(wr_wa),
      .done_o(dn_wa), .addr_b0_o(a0_wa), .ce_b0_o(ce0_wa), .we_b0_o(we0_wa), .d_b0_o(d0_wa),
      .addr_b1_o(a1_wa), .ce_b1_o(ce1_wa), .we_b1_o(we1_wa), .d_b1_o(d1_wa));

   int          nw_sat = 0, nw_wrap = 0;
   logic [31:0] last_sat = '0, last_wrap = '0;
   always @(posedge clk) begin
      if (we1_sa) begin nw_sat <= nw_sat + 1; last_sat <= d1_sa; end
      if (we1_wa) begin nw_wrap <= nw_wrap + 1; last_wrap <= d1_wa; end
   end

   // BRAM models with one-cycle read latency.
   logic [31:0] mem0 [256];
   logic [63:0] mem1 [256];
   logic [63:0] exp_d [256];
   always @(posedge clk) begin
      if (ce_b0) q_b0 <= mem0[addr_b0];
      if (we_b1) mem1[addr_b1] <= d_b1;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0, errors = 0;
   task automatic check(string name, logic [63:0] act, logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, expv, $time);
      end
   endtask

   // Reference: lane sums of rows 0..k, reduced modulo 2^ACC_W.
   task automatic build_model(int n);
      int sum [LANES];
      for (int l = 0; l < LANES; l++) sum[l] = 0;
      for (int k = 0; k < n; k++) begin
         logic [63:0] row;
         row = '0;
         for (int l = 0; l < LANES; l++) begin
            sum[l] += int'(mem0[k][l*IN_W +: IN_W]);
            row[l*ACC_W +: ACC_W] = 16'(sum[l] % 65536);
         end
         exp_d[k] = row;
      end
   endtask

   int job_E = 0, job_n = 0, job_mode = 0;
   bit job_active = 0;
   int rd_cnt, wr_cnt, wr_c, done_c, last_rd;

   int mon_c, mon_end;
   bit e_idle, e_rd, e_wr, e_done;
   always @(negedge clk) begin
      mon_c = 0;
      if (!reset_n || !job_active) begin
         e_idle = 1; e_rd = 0; e_wr = 0; e_done = 0;
      end else begin
         mon_c   = cyc - job_E + 1;
         mon_end = (job_n == 0) ? 1 : job_n + 3;
         e_done  = (mon_c == mon_end);
         e_idle  = (mon_c > mon_end);
         e_rd    = (job_n > 0) && (mon_c >= 1) && (mon_c <= job_n);
         e_wr    = (job_n > 0) && ((job_mode != 0) ? (mon_c == job_n + 2)
                                                   : (mon_c >= 3 && mon_c <= job_n + 2));
         if (read_o) begin rd_cnt++; last_rd = int'(addr_b0); end
         if (write_o) begin wr_cnt++; wr_c = mon_c; end
         if (done_o) done_c = mon_c;
      end
      check("status", 64'({idle_o, read_o, ce_b0, done_o, write_o, ce_b1, we_b1, we_b0}),
            64'({e_idle, e_rd, e_rd, e_done, e_wr, e_wr, e_wr, 1'b0}));
      check("d_b0", 64'(d_b0), 64'd0);
      if (e_rd && read_o) check("addr_b0", 64'(addr_b0), 64'(mon_c - 1));
      if (e_wr && write_o) begin
         check("addr_b1", 64'(addr_b1), (job_mode != 0) ? 64'd0 : 64'(mon_c - 3));
         check("d_b1", d_b1, (job_mode != 0) ? exp_d[job_n-1] : exp_d[mon_c-3]);
      end
   end

   task automatic check_reset_outputs(string tag);
      check({tag, "_idle"}, 64'(idle_o), 64'd1);
      check({tag, "_strobes"}, 64'({read_o, ce_b0, write_o, ce_b1, we_b1, done_o, we_b0}), 64'd0);
      check({tag, "_addr"}, 64'({addr_b0, addr_b1}), 64'd0);
      check({tag, "_data"}, d_b1, 64'd0);
   endtask

   task automatic run_job(int n, int m, bit glitch, int abort_c);
      int endc;
      endc = (n == 0) ? 1 : n + 3;
      @(negedge clk);
      run_count_i = 9'(n);
      mode_i      = 1'(m);
      start_i     = 1'b1;
      @(posedge clk);
      #1;
      job_E = cyc; job_n = n; job_mode = m;
      build_model(n);
      rd_cnt = 0; wr_cnt = 0; wr_c = -1; done_c = -1; last_rd = -1;
      job_active = 1;
      start_i = 1'b0;
      for (int c = 1; c <= endc; c++) begin
         @(negedge clk);
         if (abort_c == c) begin
            #2;
            reset_n = 1'b0;
            job_active = 0;
            #1;
            check_reset_outputs("midrun_reset");
            repeat (2) @(negedge clk);
            #2 reset_n = 1'b1;
            return;
         end
         if (glitch) begin
            start_i     = 1'($urandom_range(0, 1));
            run_count_i = 9'($urandom);
            mode_i      = 1'($urandom);
         end
      end
      start_i = 1'b0;
      #1;
      $display("job n=%0d mode=%0d reads=%0d writes=%0d done_cycle=%0d", n, m, rd_cnt, wr_cnt, done_c);
   endtask

   initial begin
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      for (int k = 0; k < 256; k++) begin mem0[k] = $urandom; mem1[k] = '0; end
      repeat (3) @(negedge clk);
      #1 check_reset_outputs("reset");
      #1 reset_n = 1'b1;

      mem0[0] = {8'd4, 8'd3, 8'd2, 8'd1};
      mem0[1] = {8'd40, 8'd30, 8'd20, 8'd10};
      mem0[2] = {8'd100, 8'd100, 8'd100, 8'd100};

      run_job(3, 0, 0, 0);
      check("basic_row0", mem1[0], {16'd4, 16'd3, 16'd2, 16'd1});
      check("basic_row1", mem1[1], {16'd44, 16'd33, 16'd22, 16'd11});
      check("basic_row2", mem1[2], {16'd144, 16'd133, 16'd122, 16'd111});
      check("basic_done_cycle", 64'(done_c), 64'd6);
      check("basic_writes", 64'(wr_cnt), 64'd3);

      run_job(3, 1, 0, 0);
      check("final_writes", 64'(wr_cnt), 64'd1);
      check("final_write_cycle", 64'(wr_c), 64'd5);
      check("final_row0", mem1[0], {16'd144, 16'd133, 16'd122, 16'd111});

      run_job(0, 0, 1, 0);
      check("n0_reads", 64'(rd_cnt), 64'd0);
      check("n0_writes", 64'(wr_cnt), 64'd0);
      check("n0_done_cycle", 64'(done_c), 64'd1);

      run_job(256, 0, 0, 0);
      check("full_reads", 64'(rd_cnt), 64'd256);
      check("full_last_addr", 64'(last_rd), 64'd255);
      check("full_writes", 64'(wr_cnt), 64'd256);
      check("full_done_cycle", 64'(done_c), 64'd259);
      check("full_row255", mem1[255], exp_d[255]);

      for (int j = 0; j < 20; j++) begin
         int n, m;
         n = $urandom_range(1, 24);
         m = $urandom_range(0, 1);
         run_job(n, m, 1, 0);
         check("rand_writes", 64'(wr_cnt), (m != 0) ? 64'd1 : 64'(n));
         check("rand_done_cycle", 64'(done_c), 64'(n + 3));
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      for (int k = 0; k < 256; k++) mem1[k] = '0;
      run_job(10, 0, 0, 5);
      run_job(2, 0, 0, 0);
      check("after_reset_row0", mem1[0], {16'd4, 16'd3, 16'd2, 16'd1});
      check("after_reset_row1", mem1[1], {16'd44, 16'd33, 16'd22, 16'd11});
      check("after_reset_row2", mem1[2], 64'd0);

      @(negedge clk) start_s = 1'b1;
      @(negedge clk) start_s = 1'b0;
      repeat (8) @(negedge clk);
      check("sat_writes", 64'(nw_sat), 64'd3);
      check("sat_final", 64'(last_sat), 64'hFFFF_FFFF);
      check("wrap_writes", 64'(nw_wrap), 64'd3);
      check("wrap_final", 64'(last_wrap), 64'hFDFD_FDFD);
      check("narrow_idle", 64'({idle_sa, idle_wa}), 64'd3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
